// File: rtl/msp_pio_gen.sv
// Parametrised bidirectional PIO port for the Avalon-MM slave fabric: per-bit direction,
// atomic output set/clear, and synchronised inputs with edge capture and a maskable level interrupt.
module msp_pio_gen #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_CAP    = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;
  // Edge detection is held off until the synchroniser and prev register hold real pin samples.
  localparam logic [2:0] ARM_MAX  = 3'(SYNC_STAGES + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [2:0]       arm_q, arm_d;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] rd;

  assign wr_en   = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_in;
    arm_d  = (arm_q == ARM_MAX) ? arm_q : arm_q + 3'd1;
  end

  always_comb begin
    det = '0;
    if (arm_q == ARM_MAX) begin
      case (EDGE_TYPE)
        0:       det = sync_in & ~prev_q;
        1:       det = ~sync_in & prev_q;
        default: det = sync_in ^ prev_q;
      endcase
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    cap_d      = cap_q;
    if (wr_en) begin
      case (address)
        A_DATA:   data_out_d = wd;
        A_DIR:    dir_d      = wd;
        A_MASK:   mask_d     = wd;
        A_CAP:    cap_d      = cap_q & ~wd;
        A_OUTSET: data_out_d = data_out_q | wd;
        A_OUTCLR: data_out_d = data_out_q & ~wd;
        default:  ;
      endcase
    end
    // A fresh edge overrides a write-1-clear landing on the same bit.
    cap_d = cap_d | det;
  end

  always_comb begin
    rd = '0;
    case (address)
      A_DATA:  rd = (data_out_q & dir_q) | (sync_in & ~dir_q);
      A_DIR:   rd = dir_q;
      A_MASK:  rd = mask_q;
      A_CAP:   rd = cap_q;
      default: rd = '0;
    endcase
  end

  assign readdata = 32'(rd);
  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      prev_q     <= '0;
      arm_q      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

endmodule

// File: tb/tb_msp_pio_gen.sv
// Bench for msp_pio_gen: directed scenarios plus randomized register/pin traffic
// checked against a cycle-level behavioural model of the port.
module tb_msp_pio_gen;

  localparam int S = 2;
  localparam int EDGE_TYPE = 0;
  localparam logic [31:0] RESET_VALUE = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] in_port = '0;
  logic [31:0] out_port;
  logic [31:0] oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_data, m_dir, m_mask, m_cap;
  logic [31:0] hist[$];   // hist[0] = most recent pin sample; sync_in = hist[S-1]
  int          ecnt;      // clock edges since reset release

  msp_pio_gen #(
    .WIDTH(32), .RESET_VALUE(RESET_VALUE), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_data = RESET_VALUE; m_dir = '0; m_mask = '0; m_cap = '0; ecnt = 0;
    hist = {};
    for (int i = 0; i < S + 1; i++) hist.push_back(32'h0);
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0:    return (m_data & m_dir) | (hist[S-1] & ~m_dir);
      3'd1:    return m_dir;
      3'd2:    return m_mask;
      3'd3:    return m_cap;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: inputs are stable from the previous negedge; model follows the edge.
  task automatic tick();
    logic [31:0] s, p, det, clr;
    bit wr;
    @(posedge clk);
    s = hist[S-1];
    p = hist[S];
    if (EDGE_TYPE == 0)      det = s & ~p;
    else if (EDGE_TYPE == 1) det = ~s & p;
    else                     det = s ^ p;
    if (ecnt < 1000) ecnt++;
    if (ecnt < S + 2) det = '0;  // pins are ignored until the pipeline has real samples
    wr  = chipselect && !write_n;
    clr = (wr && address == 3'd3) ? writedata : 32'h0;
    m_cap = (m_cap & ~clr) | det;
    if (wr) begin
      case (address)
        3'd0: m_data = writedata;
        3'd1: m_dir  = writedata;
        3'd2: m_mask = writedata;
        3'd4: m_data = m_data | writedata;
        3'd5: m_data = m_data & ~writedata;
        default: ;
      endcase
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    chipselect = 1'b0; write_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_port = '0;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      checks++;
      if (readdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, readdata, 32'h0);
      end
    end
    checks++;
    if (out_port !== RESET_VALUE || oe !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs out_port=%h oe=%h irq=%b exp %h/0/0", out_port, oe, irq, RESET_VALUE);
    end
  endtask

  task automatic test_data_dir();
    wr_reg(3'd1, 32'h0000FFFF);
    wr_reg(3'd0, 32'h12345678);
    in_port = 32'hABCD0000;
    repeat (3) tick();
    address = 3'd0;
    #1;
    checks++;
    if (readdata !== 32'hABCD5678) begin
      errors++;
      $display("FAIL data_mix got=%h exp=%h", readdata, 32'hABCD5678);
    end
    checks++;
    if (out_port !== 32'h12345678 || oe !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL data_out out_port=%h oe=%h exp 12345678/0000ffff", out_port, oe);
    end
  endtask

  task automatic test_set_clr();
    wr_reg(3'd0, 32'h000000F0);
    wr_reg(3'd4, 32'h0000000F);
    checks++;
    if (out_port !== 32'h000000FF) begin
      errors++;
      $display("FAIL outset got=%h exp=%h", out_port, 32'h000000FF);
    end
    wr_reg(3'd5, 32'h00000081);
    checks++;
    if (out_port !== 32'h0000007E) begin
      errors++;
      $display("FAIL outclr got=%h exp=%h", out_port, 32'h0000007E);
    end
    address = 3'd4;
    #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL outset_read got=%h exp=0", readdata);
    end
  endtask

  task automatic test_edge_irq();
    in_port = '0;
    do_reset();
    repeat (5) tick();
    wr_reg(3'd2, 32'h1);
    in_port = 32'h1;          // set up before edge N
    address = 3'd3;
    tick();                   // edge N
    tick();                   // edge N+1
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_early cap=%h irq=%b exp 0/0", readdata, irq);
    end
    tick();                   // edge N+2
    #1;
    checks++;
    if (readdata !== 32'h1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL edge_capture cap=%h irq=%b exp 1/1", readdata, irq);
    end
    wr_reg(3'd3, 32'h1);
    address = 3'd3;
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_clear cap=%h irq=%b exp 0/0", readdata, irq);
    end
    in_port = 32'h0;
    repeat (5) tick();
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_falling_ignored cap=%h irq=%b exp 0/0", readdata, irq);
    end
  endtask

  task automatic test_held_through_reset();
    in_port = 32'hFFFFFFFF;
    do_reset();
    wr_reg(3'd2, 32'hFFFFFFFF);
    address = 3'd3;
    for (int i = 0; i < 19; i++) begin
      tick();
      #1;
      checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL arm_suppress cycle=%0d cap=%h irq=%b exp 0/0", i, readdata, irq);
      end
    end
  endtask

  task automatic test_simultaneous();
    in_port = '0;
    do_reset();
    repeat (5) tick();
    wr_reg(3'd2, 32'h8);
    in_port = 32'h8;
    tick();
    tick();
    wr_reg(3'd3, 32'h8);      // clear lands on the same edge that captures bit 3
    address = 3'd3;
    #1;
    checks++;
    if (readdata !== 32'h8 || irq !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear cap=%h irq=%b exp 8/1", readdata, irq);
    end
    // Reset in the middle of a new capture
    wr_reg(3'd0, 32'h55);
    wr_reg(3'd3, 32'h8);
    in_port = 32'h28;
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    address = 3'd3;
    #1;
    checks++;
    if (readdata !== 32'h0 || out_port !== RESET_VALUE || irq !== 1'b0 || oe !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset cap=%h out_port=%h irq=%b oe=%h exp 0/%h/0/0", readdata, out_port, irq, oe, RESET_VALUE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) tick();
    #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_no_capture cap=%h exp 0", readdata);
    end
  endtask

  task automatic test_random();
    logic [2:0] a;
    in_port = $urandom;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = $urandom;
      a = 3'($urandom_range(0, 7));
      address = a;
      writedata = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      chipselect = ($urandom_range(0, 1) == 1);
      write_n = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (readdata !== exp_rd(a)) begin
        errors++;
        $display("FAIL rand_read i=%0d addr=%0d got=%h exp=%h", i, a, readdata, exp_rd(a));
      end
      tick();
      checks++;
      if (out_port !== m_data || oe !== m_dir || irq !== |(m_cap & m_mask)) begin
        errors++;
        $display("FAIL rand_outputs i=%0d out_port=%h oe=%h irq=%b exp %h/%h/%b",
                 i, out_port, oe, irq, m_data, m_dir, |(m_cap & m_mask));
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_data_dir();
    test_set_clr();
    test_edge_irq();
    test_held_through_reset();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msp_pio_gen.md
Name: msp_pio_gen

Overview:
Parametrised general-purpose I/O port on the MSP430 Avalon-MM slave fabric. It is the next-generation PIO and replaces the fixed 32-bit output-only port. Each bit is independently an input or an output, with atomic set/clear of outputs. Inputs pass through a synchroniser and feed edge-capture logic with a maskable, level-sensitive interrupt to the interrupt controller.

Parameters:
WIDTH, 32, number of I/O bits; legal range 1..32; register data occupies bits [WIDTH-1:0].
RESET_VALUE, 0, reset value of the output data register (WIDTH bits).
EDGE_TYPE, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
SYNC_STAGES, 2, flip-flop stages in the input synchroniser; legal range 2..4.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH-1 ignored
readdata  out  32  read data; combinational, zero wait states; bits above WIDTH-1 read 0
in_port  in  WIDTH  asynchronous external inputs
out_port  out  WIDTH  output data register
oe  out  WIDTH  per-bit output enable (= direction register)
irq  out  1  interrupt request, active high, level

Behaviour:
- Reset (async assert, sync-free release) sets:
  - data_out = RESET_VALUE
  - dir = 0, irq_mask = 0, edge_cap = 0
  - all synchroniser stages and the prev-sample register = 0
  - arm counter = 0
  - Resulting outputs: out_port = RESET_VALUE, oe = 0, irq = 0.
- Write strobe: chipselect && !write_n, sampled on the rising edge of clk. Without the strobe, no register changes.
- Register map:
  - 0 DATA: write sets data_out = wd. Read returns (data_out & dir) | (sync_in & ~dir).
  - 1 DIR: read/write; 1 = output.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns edge_cap. Writing a 1 clears that bit; writing a 0 has no effect.
  - 4 OUTSET: write sets data_out |= wd. Reads 0.
  - 5 OUTCLR: write sets data_out &= ~wd. Reads 0.
  - 6, 7: reserved. Reads 0, writes ignored.
- Readdata decode is purely combinational on address; chipselect does not gate it. Reads have no side effects.
- Synchroniser:
  - sync_in is the output of stage SYNC_STAGES.
  - A change on in_port set up before edge N appears in a DATA read after edge N+SYNC_STAGES-1.
- Edge detection:
  - prev <= sync_in every cycle.
  - det = sync_in & ~prev (rising), ~sync_in & prev (falling), or sync_in ^ prev (any).
  - Edge capture applies to all bits regardless of dir.
  - For a change before edge N, the edge_cap bit is set at edge N+SYNC_STAGES.
- Arming:
  - After reset release, det is forced to 0 until the arm counter reaches SYNC_STAGES+1.
  - The counter increments once per clk and saturates there.
  - This suppresses false edges from pins already high or low at reset release.
- Simultaneous events:
  - Edge detect and a write-1-clear on the same bit in the same cycle: the set wins and the bit stays 1.
  - data_out changes only on writes to 0, 4 and 5; there is no conflict inside a single write.
- irq = |(edge_cap & irq_mask), driven combinationally from registers:
  - Asserts the cycle edge_cap or irq_mask becomes nonzero in an overlapping bit.
  - Deasserts the cycle after the clearing write edge.
- Reset mid-operation:
  - All state returns to reset values immediately, including a capture in flight.
  - The arm counter restarts.
- WIDTH < 32: writedata bits above WIDTH-1 have no effect; readdata bits above WIDTH-1 are 0.

Test Plan:
1. Reset, then read each address -> DATA = 0 (RESET_VALUE = 0, dir = 0, in_port = 0), other registers 0; out_port = 0, oe = 0, irq = 0.
2. Write DIR = 0x0000FFFF, DATA = 0x12345678, in_port = 0xABCD0000, wait 3 cycles, read DATA -> 0xABCD5678; out_port = 0x12345678.
3. DATA = 0x000000F0, then OUTSET 0x0000000F -> out_port = 0x000000FF; OUTCLR 0x00000081 -> 0x0000007E; read address 4 -> 0.
4. EDGE_TYPE = 0: IRQ_MASK = 0x1; raise in_port[0] before edge N -> edge_cap[0] = 1 at edge N+2 and irq = 1; write 0x1 to EDGE_CAP -> irq = 0 next cycle; falling in_port[0] -> no capture.
5. Hold in_port = 0xFFFFFFFF through reset release -> edge_cap stays 0 and irq stays 0 for 20 cycles.
6. Rising edge on bit 3 timed so det coincides with a write of 0x8 to EDGE_CAP -> edge_cap[3] = 1. Separately, assert reset_n low mid-capture -> edge_cap = 0 and out_port = RESET_VALUE within the same cycle.
